// File: rtl/pwm_fade_seq.sv
// pwm_fade_seq: drives the 4-bit duty input of a pwm block through a fade
// envelope: ramp up to a latched peak, hold, then ramp back down to zero.
// Optionally loops instead of finishing.
//
// Optional feature: define PWM_FADE_GAMMA_EN to map the linear level through
// a 16-entry perceptual table before it reaches duty. Without the macro,
// duty follows the linear level directly and no table is built.
module pwm_fade_seq #(
  parameter int STEP_CYCLES = 1000000,
  parameter int HOLD_CYCLES = 4000000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] max_duty,
  input  logic       loop,
  output logic [3:0] duty,
  output logic       busy,
  output logic       done,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Terminal dwell values; the counter runs 0..N-1 in each level/state.
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg,   state_next;
  logic [3:0]       level_reg,   level_next;
  logic [CNT_W-1:0] dwell_reg,   dwell_next;
  logic [3:0]       max_lat_reg, max_lat_next;
  logic             done_reg,    done_next;
  logic [3:0]       duty_reg,    duty_next;
  logic             busy_reg;
  logic [1:0]       phase_reg;
  logic             dwell_term;

`ifdef PWM_FADE_GAMMA_EN
  // Perceptual brightness curve, indexed by the linear level.
  localparam logic [3:0] GAMMA_LUT [16] = '{
    4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
    4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15
  };

  // Duty is looked up from the next level so it lines up with level timing.
  always_comb begin
    duty_next = GAMMA_LUT[level_next];
  end
`else
  // Duty tracks the next level directly so it is registered alongside it.
  always_comb begin
    duty_next = level_next;
  end
`endif

  // Terminal detect: HOLD uses its own dwell length, both ramps share one.
  always_comb begin
    dwell_term = (state_reg == HOLD) ? (dwell_reg == HOLD_LAST)
                                     : (dwell_reg == STEP_LAST);
  end

  // Next-state, level, dwell and done logic for the fade sequencer.
  always_comb begin
    state_next   = state_reg;
    level_next   = level_reg;
    dwell_next   = dwell_reg + CNT_W'(1);
    max_lat_next = max_lat_reg;
    done_next    = 1'b0;

    if (state_reg != IDLE && stop) begin
      // Abort from any active state: back to a clean idle, no done pulse.
      state_next = IDLE;
      level_next = 4'd0;
      dwell_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          level_next = 4'd0;
          dwell_next = '0;
          // stop wins over a simultaneous start.
          if (start && !stop) begin
            max_lat_next = max_duty;
            state_next   = RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (dwell_term) begin
            dwell_next = '0;
            if (level_reg == max_lat_reg) begin
              state_next = HOLD;
            end else begin
              level_next = level_reg + 4'd1;
            end
          end
        end
        HOLD: begin
          if (dwell_term) begin
            dwell_next = '0;
            state_next = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (dwell_term) begin
            dwell_next = '0;
            if (level_reg != 4'd0) begin
              level_next = level_reg - 4'd1;
            end else if (loop) begin
              // Looping re-latches the peak so a new max_duty takes effect.
              max_lat_next = max_duty;
              state_next   = RAMP_UP;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          level_next = 4'd0;
          dwell_next = '0;
        end
      endcase
    end
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      level_reg   <= 4'd0;
      dwell_reg   <= '0;
      max_lat_reg <= 4'd0;
      done_reg    <= 1'b0;
      duty_reg    <= 4'd0;
      busy_reg    <= 1'b0;
      phase_reg   <= 2'd0;
    end else begin
      state_reg   <= state_next;
      level_reg   <= level_next;
      dwell_reg   <= dwell_next;
      max_lat_reg <= max_lat_next;
      done_reg    <= done_next;
      duty_reg    <= duty_next;
      busy_reg    <= (state_next != IDLE);
      phase_reg   <= state_next;
    end
  end

  assign duty  = duty_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign phase = phase_reg;

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Directed testbench for pwm_fade_seq with STEP_CYCLES=4, HOLD_CYCLES=8.
// Expected duty values follow the gamma table when PWM_FADE_GAMMA_EN is set.
module tb_pwm_fade_seq;

  localparam int S = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] max_duty;
  logic       loop;
  logic [3:0] duty;
  logic       busy;
  logic       done;
  logic [1:0] phase;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_fade_seq #(
    .STEP_CYCLES(S),
    .HOLD_CYCLES(H),
    .CNT_W(28)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .max_duty(max_duty),
    .loop(loop),
    .duty(duty),
    .busy(busy),
    .done(done),
    .phase(phase)
  );

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int gamma_of(input int l);
    case (l)
      0, 1, 2:  return 0;
      3, 4, 5:  return 1;
      6, 7:     return 2;
      8:        return 3;
      9:        return 4;
      10:       return 5;
      11:       return 6;
      12:       return 8;
      13:       return 10;
      14:       return 12;
      default:  return 15;
    endcase
  endfunction

  function automatic int exp_duty(input int l);
`ifdef PWM_FADE_GAMMA_EN
    return gamma_of(l);
`else
    return l;
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, " duty"},  32'(duty),  0);
    chk({tag, " busy"},  32'(busy),  0);
    chk({tag, " done"},  32'(done),  0);
    chk({tag, " phase"}, 32'(phase), 0);
  endtask

  // Present a start pulse; returns just after the accepting edge.
  task automatic launch(input int m);
    max_duty = 4'(m);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Check the whole envelope for peak m, cycle by cycle from the accept edge.
  task automatic follow(input int m, input int new_max, input bit pulse_start);
    int ramp  = (m + 1) * S;
    int total = 2 * ramp + H;
    int lvl;
    int ph;
    for (int k = 0; k < total; k++) begin
      if (k < ramp) begin
        lvl = k / S;
        ph  = 1;
      end else if (k < ramp + H) begin
        lvl = m;
        ph  = 2;
      end else begin
        lvl = m - (k - ramp - H) / S;
        ph  = 3;
      end
      chk($sformatf("m=%0d k=%0d duty", m, k),  32'(duty),  exp_duty(lvl));
      chk($sformatf("m=%0d k=%0d phase", m, k), 32'(phase), ph);
      chk($sformatf("m=%0d k=%0d busy", m, k),  32'(busy),  1);
      chk($sformatf("m=%0d k=%0d done", m, k),  32'(done),  0);
      if (new_max >= 0 && k == ramp + 2) max_duty = new_max[3:0];
      start = (pulse_start && k == ramp + 3);
      step();
    end
    start = 1'b0;
  endtask

  task automatic done_check(input string tag);
    chk({tag, " done pulse"}, 32'(done),  1);
    chk({tag, " busy"},       32'(busy),  0);
    chk({tag, " phase"},      32'(phase), 0);
    chk({tag, " duty"},       32'(duty),  0);
    step();
    chk({tag, " done cleared"}, 32'(done), 0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    loop     = 1'b0;
    max_duty = 4'd0;

    // 1. reset, then quiet idle
    repeat (3) step();
    reset = 1'b0;
    chk_idle("reset");
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle($sformatf("idle%0d", i));
    end

    // 2. peak 3, done at T+40
    launch(3);
    follow(3, -1, 1'b0);
    done_check("m3");
    $display("fade m=3 complete");

    // 3. peak 0 (done at T+16) and peak 15 (done at T+136)
    launch(0);
    follow(0, -1, 1'b0);
    done_check("m0");
    $display("fade m=0 complete");
    launch(15);
    follow(15, -1, 1'b0);
    done_check("m15");
    $display("fade m=15 complete");

    // 4. stop at level 2, then restart from level 0
    launch(3);
    repeat (9) step();
    chk("stop pre duty",  32'(duty),  exp_duty(2));
    chk("stop pre phase", 32'(phase), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_idle("after stop");
    step();
    chk("stop no done", 32'(done), 0);
    launch(3);
    follow(3, -1, 1'b0);
    done_check("restart");
    $display("stop/restart complete");

    // 5. loop with peak change during HOLD
    loop = 1'b1;
    launch(2);
    follow(2, 1, 1'b0);
    chk("loop phase", 32'(phase), 1);
    chk("loop busy",  32'(busy),  1);
    chk("loop done",  32'(done),  0);
    chk("loop duty",  32'(duty),  exp_duty(0));
    loop = 1'b0;
    follow(1, -1, 1'b0);
    done_check("loop end");
    $display("loop pass complete");

    // 6. start during HOLD ignored; start+stop in idle stays idle
    launch(2);
    follow(2, -1, 1'b1);
    done_check("hold start");
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk_idle("start+stop");
    repeat (3) step();
    chk_idle("start+stop later");
    $display("start/stop corner complete");

    // reset during done pulse and mid-fade
    launch(0);
    follow(0, -1, 1'b0);
    chk("pre-reset done", 32'(done), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("reset at done");
    launch(3);
    repeat (20) step();
    chk("pre-reset phase", 32'(phase), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("reset mid-fade");
    step();
    chk_idle("after reset mid-fade");
    $display("reset cases complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
